lemming_arena: RTL and testbench

LEMMING_ARENA -- requirements
Module: lemming_arena

---
 rtl/lemming_pkg.sv | 20 ++
 rtl/step_prescaler.sv | 29 ++
 rtl/lemming_arena.sv | 94 +++++++++
 tb/tb_lemming_arena.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lemming_pkg.sv
// Shared types and default constants for the lemming arena and the lemming walker FSM.
package lemming_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        BUMP = 2'd2,
        ERR  = 2'd3
    } arena_state_t;

    localparam int DEF_ARENA_LEN = 16;
    localparam int DEF_STEP_DIV  = 4;
    localparam int DEF_START_POS = 8;

    // Bump counter stops at all-ones instead of wrapping back to zero.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/step_prescaler.sv
// Divides the clock into movement steps: tick marks the last cycle of each STEP_DIV-cycle period.
module step_prescaler
    import lemming_pkg::*;
#(
    parameter int STEP_DIV = DEF_STEP_DIV
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic run,
    output logic tick
);

    localparam int            CW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] count;

    // The count only moves while running, so a pause resumes mid-period.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            count <= '0;
        end else if (run) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

    assign tick = run && (count == LAST);

endmodule

// File: rtl/lemming_arena.sv
// One-dimensional corridor: moves the lemming one cell per step and reports wall hits and walk-protocol errors.
module lemming_arena
    import lemming_pkg::*;
#(
    parameter int ARENA_LEN = DEF_ARENA_LEN,
    parameter int STEP_DIV  = DEF_STEP_DIV,
    parameter int START_POS = DEF_START_POS
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic                         en,
    input  logic                         walk_left,
    input  logic                         walk_right,
    output logic                         bump_left,
    output logic                         bump_right,
    output logic [$clog2(ARENA_LEN)-1:0] pos,
    output logic [7:0]                   bump_cnt,
    output logic                         proto_err,
    output logic [1:0]                   dbg_state
);

    localparam int            PW      = $clog2(ARENA_LEN);
    localparam logic [PW-1:0] POS_MAX = PW'(ARENA_LEN - 1);
    localparam logic [PW-1:0] POS_RST = PW'(START_POS);

    arena_state_t state;
    logic         run;
    logic         tick;

    assign run = en && (state == RUN);

    step_prescaler #(
        .STEP_DIV(STEP_DIV)
    ) u_prescaler (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .run    (run),
        .tick   (tick)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            pos        <= POS_RST;
            bump_left  <= 1'b0;
            bump_right <= 1'b0;
            bump_cnt   <= 8'd0;
            proto_err  <= 1'b0;
        end else begin
            bump_left  <= 1'b0;
            bump_right <= 1'b0;
            case (state)
                IDLE: if (en) state <= RUN;
                RUN: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (tick) begin
                        // Walk inputs only matter on a step; the pulse lands in the BUMP cycle.
                        case ({walk_left, walk_right})
                            2'b10: begin
                                if (pos == '0) begin
                                    state     <= BUMP;
                                    bump_left <= 1'b1;
                                    bump_cnt  <= sat_inc8(bump_cnt);
                                end else begin
                                    pos <= pos - PW'(1);
                                end
                            end
                            2'b01: begin
                                if (pos == POS_MAX) begin
                                    state      <= BUMP;
                                    bump_right <= 1'b1;
                                    bump_cnt   <= sat_inc8(bump_cnt);
                                end else begin
                                    pos <= pos + PW'(1);
                                end
                            end
                            default: begin
                                state     <= ERR;
                                proto_err <= 1'b1;
                            end
                        endcase
                    end
                end
                BUMP:    state <= en ? RUN : IDLE;
                ERR:     state <= ERR;
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_lemming_arena.sv
// Bench for lemming_arena: default-size arena plus a 2-cell, every-cycle arena, both tracked by a step model.
`timescale 1ns/1ps
module tb_lemming_arena;
    import lemming_pkg::*;

    localparam int S_LEN   = 2;
    localparam int S_DIV   = 1;
    localparam int S_START = 1;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_BUMP = 2;
    localparam int M_ERR  = 3;

    // ---------------- clock ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- default arena ----------------
    logic       rst = 1'b1, en = 1'b0, wl = 1'b0, wr = 1'b0;
    logic       bl, br, perr;
    logic [3:0] pos;
    logic [7:0] cnt;
    logic [1:0] st;

    lemming_arena dut (
        .sys_clk   (clk),
        .sys_rst   (rst),
        .en        (en),
        .walk_left (wl),
        .walk_right(wr),
        .bump_left (bl),
        .bump_right(br),
        .pos       (pos),
        .bump_cnt  (cnt),
        .proto_err (perr),
        .dbg_state (st)
    );

    // ---------------- small arena ----------------
    logic       s_rst = 1'b1, s_en = 1'b0, s_wl = 1'b0, s_wr = 1'b0;
    logic       s_bl, s_br, s_perr;
    logic [0:0] s_pos;
    logic [7:0] s_cnt;
    logic [1:0] s_st;
    bit         s_done = 1'b0;

    lemming_arena #(
        .ARENA_LEN(S_LEN),
        .STEP_DIV (S_DIV),
        .START_POS(S_START)
    ) dut_s (
        .sys_clk   (clk),
        .sys_rst   (s_rst),
        .en        (s_en),
        .walk_left (s_wl),
        .walk_right(s_wr),
        .bump_left (s_bl),
        .bump_right(s_br),
        .pos       (s_pos),
        .bump_cnt  (s_cnt),
        .proto_err (s_perr),
        .dbg_state (s_st)
    );

    // ---------------- scoreboard ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        int mode;
        int phase;   // run cycles elapsed in the current step
        int pos;
        int cnt;
        bit bl;
        bit br;
        bit perr;
    } mdl_t;

    function automatic mdl_t mdl_next(input mdl_t m, input int len, input int div, input int start,
                                      input logic r, input logic e, input logic l, input logic rt);
        mdl_t n = m;
        n.bl = 1'b0;
        n.br = 1'b0;
        if (r) begin
            n.mode = M_IDLE; n.phase = 0; n.pos = start; n.cnt = 0; n.perr = 1'b0;
            return n;
        end
        if (m.mode == M_IDLE) begin
            if (e) n.mode = M_RUN;
        end else if (m.mode == M_RUN) begin
            if (!e) n.mode = M_IDLE;
            else if (m.phase + 1 < div) n.phase = m.phase + 1;
            else begin
                n.phase = 0;
                if (l == rt) begin
                    n.mode = M_ERR; n.perr = 1'b1;
                end else begin
                    int target = l ? m.pos - 1 : m.pos + 1;
                    if (target < 0 || target >= len) begin
                        n.mode = M_BUMP;
                        n.bl   = l;
                        n.br   = rt;
                        n.cnt  = (m.cnt + 1 > 255) ? 255 : m.cnt + 1;
                    end else begin
                        n.pos = target;
                    end
                end
            end
        end else if (m.mode == M_BUMP) begin
            n.mode = e ? M_RUN : M_IDLE;
        end
        return n;
    endfunction

    function automatic int exp_state(input int mode);
        case (mode)
            M_RUN:   return int'(RUN);
            M_BUMP:  return int'(BUMP);
            M_ERR:   return int'(ERR);
            default: return int'(IDLE);
        endcase
    endfunction

    mdl_t ma = '0;
    mdl_t mb = '0;
    bit   chk_on = 1'b0;

    always @(posedge clk) begin
        ma <= mdl_next(ma, 16, 4, 8, rst, en, wl, wr);
        mb <= mdl_next(mb, S_LEN, S_DIV, S_START, s_rst, s_en, s_wl, s_wr);
    end

    task automatic cmp_model(input string tag, input mdl_t m, input int p, input int l, input int r,
                             input int c, input int e, input int s);
        check({tag, "_pos"},   p, m.pos);
        check({tag, "_bl"},    l, int'(m.bl));
        check({tag, "_br"},    r, int'(m.br));
        check({tag, "_cnt"},   c, m.cnt);
        check({tag, "_perr"},  e, int'(m.perr));
        check({tag, "_state"}, s, exp_state(m.mode));
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp_model("a", ma, int'(pos), int'(bl), int'(br), int'(cnt), int'(perr), int'(st));
            cmp_model("b", mb, int'(s_pos), int'(s_bl), int'(s_br), int'(s_cnt), int'(s_perr), int'(s_st));
        end
    end

    // ---------------- small arena: bounce until the counter saturates ----------------
    initial begin
        bit sdir;
        int prev;
        int wrapped;
        sdir = 1'b1; prev = 0; wrapped = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        s_rst = 1'b0; s_en = 1'b1;
        repeat (900) begin
            s_wr = sdir; s_wl = !sdir;
            @(posedge clk);
            @(negedge clk);
            if (s_br) sdir = 1'b0;
            if (s_bl) sdir = 1'b1;
            if (int'(s_cnt) < prev) wrapped++;
            prev = int'(s_cnt);
        end
        check("small_sat", int'(s_cnt), 255);
        check("small_nowrap", wrapped, 0);
        check("small_perr", int'(s_perr), 0);
        s_done = 1'b1;
    end

    // ---------------- default arena: directed then random ----------------
    initial begin
        bit dir;
        int last_side, side, alt_bad, n_bumps, pmin, pmax, frozen_bad, waitc;

        // reset held for two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_on = 1'b1;
        check("rst_pos", int'(pos), 8);
        check("rst_cnt", int'(cnt), 0);
        check("rst_perr", int'(perr), 0);
        check("rst_bl", int'(bl), 0);
        check("rst_br", int'(br), 0);
        check("rst_state", int'(st), int'(IDLE));

        // walk right to the wall: IDLE->RUN edge, then a step every 4 cycles
        rst = 1'b0; en = 1'b1; wr = 1'b1; wl = 1'b0;
        repeat (29) @(posedge clk);
        @(negedge clk);
        check("walk_pos15", int'(pos), 15);
        check("walk_br_early", int'(br), 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("wall_br", int'(br), 1);
        check("wall_bl", int'(bl), 0);
        check("wall_cnt", int'(cnt), 1);
        check("wall_pos", int'(pos), 15);

        // reset lands in the BUMP cycle
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bumprst_br", int'(br), 0);
        check("bumprst_pos", int'(pos), 8);
        check("bumprst_cnt", int'(cnt), 0);

        // illegal encoding on the first step
        rst = 1'b0; en = 1'b1; wl = 1'b1; wr = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("illegal_perr", int'(perr), 1);
        check("illegal_pos", int'(pos), 8);
        check("illegal_state", int'(st), int'(ERR));
        frozen_bad = 0;
        repeat (20) begin
            wl = 1'($urandom); wr = 1'($urandom); en = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            if (pos != 4'd8 || bl || br || !perr || cnt != 8'd0) frozen_bad++;
        end
        check("err_frozen", frozen_bad, 0);

        // closed loop with a walker that turns around on every bump
        rst = 1'b1; en = 1'b0; wl = 1'b0; wr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; en = 1'b1; dir = 1'b1;
        last_side = 0; alt_bad = 0; n_bumps = 0; pmin = 99; pmax = -1;
        repeat (200) begin
            wr = dir; wl = !dir;
            @(posedge clk);
            @(negedge clk);
            if (br || bl) begin
                side = br ? 1 : 2;
                if (side == last_side) alt_bad++;
                last_side = side;
                n_bumps++;
                dir = bl;
            end
            if (int'(pos) < pmin) pmin = int'(pos);
            if (int'(pos) > pmax) pmax = int'(pos);
        end
        check("loop_alternate", alt_bad, 0);
        check("loop_bumps_ge3", int'(n_bumps >= 3), 1);
        check("loop_pmin", pmin, 0);
        check("loop_pmax", pmax, 15);
        check("loop_perr", int'(perr), 0);
        check("loop_cnt", int'(cnt), n_bumps);

        // random traffic: pauses, direction changes, occasional bad encodings and resets
        dir = 1'($urandom);
        repeat (1500) begin
            rst = ($urandom_range(0, 99) < 2);
            en  = ($urandom_range(0, 99) < 90);
            if ($urandom_range(0, 99) < 4) dir = !dir;
            if ($urandom_range(0, 99) < 2) begin
                wl = 1'($urandom_range(0, 1)); wr = wl;
            end else begin
                wr = dir; wl = !dir;
            end
            @(posedge clk);
            @(negedge clk);
            if ((bl || br) && $urandom_range(0, 99) < 50) dir = bl;
        end

        waitc = 0;
        while (!s_done && waitc < 3000) begin
            @(posedge clk);
            waitc++;
        end
        check("small_done", int'(s_done), 1);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
